// File: rtl/uart_rom_loader.sv
// uart_rom_loader: parses a framed program image from UART bytes into ROM writes while holding the CPU in reset
module uart_rom_loader #(
    parameter int         ROM_DEPTH      = 4096,
    parameter int         TIMEOUT_CYCLES = 10000000,
    parameter logic [7:0] HEADER         = 8'hAA
) (
    input  logic        CLK_100MHz,
    input  logic        RESET_N,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic        ROM_WE,
    output logic [15:0] ROM_ADDR,
    output logic [15:0] ROM_DATA,
    output logic        CPU_HOLD,
    output logic        LOAD_DONE,
    output logic        LOAD_ERR
);
    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [16:0] MAX_COUNT = 17'(ROM_DEPTH);

    typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR} state_t;

    state_t state, state_next;
    logic [7:0] cnt_hi, data_hi, chk;
    logic [15:0] remaining, wr_ptr, frame_count;
    logic [GW-1:0] gap;
    logic active, timeout, header_ok;

    assign frame_count = {cnt_hi, RX_DATA};
    assign active = state == CNT_HI || state == CNT_LO || state == DATA_HI || state == DATA_LO || state == CHECK;
    // A byte arriving on the limit cycle wins because timeout requires RX_VALID low.
    assign timeout = active && !RX_VALID && gap == GW'(TIMEOUT_CYCLES - 1);
    assign header_ok = state == IDLE && RX_VALID && RX_DATA == HEADER;
    assign CPU_HOLD = state != IDLE;
    assign LOAD_DONE = state == DONE;

    // State register.
    always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else state <= state_next;
    end

    // Next-state decode: one byte advances one field; a stalled stream times out to ERROR.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (header_ok) state_next = CNT_HI;
            CNT_HI:  if (RX_VALID) state_next = CNT_LO;
            CNT_LO:  if (RX_VALID) state_next = {1'b0, frame_count} > MAX_COUNT ? ERROR :
                                                frame_count == 16'd0 ? CHECK : DATA_HI;
            DATA_HI: if (RX_VALID) state_next = DATA_LO;
            DATA_LO: if (RX_VALID) state_next = remaining == 16'd1 ? CHECK : DATA_HI;
            CHECK:   if (RX_VALID) state_next = RX_DATA == chk ? DONE : ERROR;
            default: state_next = IDLE;
        endcase
        if (timeout) state_next = ERROR;
    end

    // Datapath: count/data latching, checksum, ROM write strobe, gap counter and sticky error.
    always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            ROM_WE    <= 1'b0;
            ROM_ADDR  <= '0;
            ROM_DATA  <= '0;
            LOAD_ERR  <= 1'b0;
            cnt_hi    <= '0;
            data_hi   <= '0;
            chk       <= '0;
            remaining <= '0;
            wr_ptr    <= '0;
            gap       <= '0;
        end else begin
            ROM_WE <= 1'b0;
            gap <= (!active || RX_VALID) ? '0 : gap + 1'b1;
            if (header_ok) begin
                wr_ptr   <= '0;
                chk      <= '0;
                LOAD_ERR <= 1'b0;
            end
            if (state_next == ERROR && state != ERROR) LOAD_ERR <= 1'b1;
            if (RX_VALID) begin
                case (state)
                    CNT_HI:  cnt_hi <= RX_DATA;
                    CNT_LO:  remaining <= frame_count;
                    DATA_HI: begin
                        data_hi <= RX_DATA;
                        chk     <= chk + RX_DATA;
                    end
                    DATA_LO: begin
                        ROM_WE    <= 1'b1;
                        ROM_ADDR  <= wr_ptr;
                        ROM_DATA  <= {data_hi, RX_DATA};
                        wr_ptr    <= wr_ptr + 16'd1;
                        remaining <= remaining - 16'd1;
                        chk       <= chk + RX_DATA;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rom_loader.sv
// tb_uart_rom_loader: directed and randomized frame tests against a byte-level frame model
module tb_uart_rom_loader;
    localparam int DEPTH = 16;
    localparam int TMO   = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic rx_valid = 1'b0;
    logic rom_we, cpu_hold, load_done, load_err;
    logic [15:0] rom_addr, rom_data;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [31:0] wq[$];

    uart_rom_loader #(.ROM_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .HEADER(8'hAA)) dut (
        .CLK_100MHz(clk),
        .RESET_N(rst_n),
        .RX_DATA(rx_data),
        .RX_VALID(rx_valid),
        .ROM_WE(rom_we),
        .ROM_ADDR(rom_addr),
        .ROM_DATA(rom_data),
        .CPU_HOLD(cpu_hold),
        .LOAD_DONE(load_done),
        .LOAD_ERR(load_err)
    );

    always #5 clk = ~clk;

    // Record every ROM write and completion pulse, sampled away from the active edge.
    always @(negedge clk) begin
        if (rom_we === 1'b1) wq.push_back({rom_addr, rom_data});
        if (load_done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: locate the header, read the count, list the expected writes and decide done/error.
    task automatic run_frame(input logic [7:0] f[$], input int gapmax, input string tag);
        int base = wq.size();
        int d0 = done_cnt;
        logic [31:0] ew[$];
        int h = 0;
        int cnt;
        logic [7:0] s = 8'h00;
        bit err = 1'b0;
        bit good = 1'b0;
        while (f[h] != 8'hAA) h++;
        cnt = int'({f[h+1], f[h+2]});
        if (cnt > DEPTH) err = 1'b1;
        else begin
            for (int i = 0; i < cnt; i++) begin
                ew.push_back({16'(i), f[h+3+2*i], f[h+4+2*i]});
                s = s + f[h+3+2*i] + f[h+4+2*i];
            end
            good = s == f[h+3+2*cnt];
            err = !good;
        end
        foreach (f[i]) begin
            send(f[i]);
            if (gapmax > 0) idle($urandom_range(0, gapmax));
        end
        idle(3);
        check({tag, "_nwrites"}, wq.size() - base, ew.size());
        for (int i = 0; i < ew.size(); i++)
            check({tag, "_write"}, (base + i < wq.size()) ? wq[base+i] : 32'hxxxxxxxx, ew[i]);
        check({tag, "_done"}, done_cnt - d0, good ? 1 : 0);
        check({tag, "_err"}, load_err, err);
        check({tag, "_hold"}, cpu_hold, 0);
    endtask

    initial begin
        int base;
        logic [7:0] f[$];
        idle(2);
        check("reset_outs", {rom_we, cpu_hold, load_done, load_err, rom_addr, rom_data[11:0]}, 0);
        rst_n = 1'b1;
        idle(1);

        // Valid 2-word frame; data bytes 12 34 AB CD sum to BE mod 256.
        base = wq.size();
        send(8'hAA);
        check("hold_rise", cpu_hold, 1);
        send(8'h00); send(8'h02); send(8'h12); send(8'h34);
        check("we0", {rom_we, rom_addr, rom_data}, {1'b1, 16'h0000, 16'h1234});
        send(8'hAB);
        check("we_single", rom_we, 0);
        send(8'hCD);
        check("we1", {rom_we, rom_addr, rom_data}, {1'b1, 16'h0001, 16'hABCD});
        send(8'hBE);
        check("done_pulse", {load_done, cpu_hold, load_err}, 3'b110);
        idle(1);
        check("hold_fall", {load_done, cpu_hold, load_err}, 3'b000);
        check("frame1_writes", wq.size() - base, 2);

        run_frame('{8'hAA, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h8F}, 0, "badchk");
        run_frame('{8'h55, 8'h00, 8'hAA, 8'h00, 8'h00, 8'h00}, 0, "zero");

        // Oversize count: ERROR immediately after the low count byte, no writes.
        base = wq.size();
        send(8'hAA); send(8'h00); send(8'(DEPTH + 1));
        check("over_err", {load_err, cpu_hold}, 2'b11);
        idle(3);
        check("over_nowrite", wq.size() - base, 0);
        check("over_hold", cpu_hold, 0);

        // Timeout: header clears the old error, then 100 silent cycles raise it.
        send(8'hAA);
        check("hdr_clr_err", load_err, 0);
        send(8'h00); send(8'h01); send(8'h12);
        idle(TMO - 1);
        check("tmo_early", {load_err, cpu_hold}, 2'b01);
        idle(1);
        check("tmo_err", load_err, 1);
        idle(1);
        check("tmo_hold", cpu_hold, 0);
        run_frame('{8'hAA, 8'h00, 8'h01, 8'h12, 8'h34, 8'h46}, 2, "after_tmo");

        // Reset mid-load, then a clean reload from address 0.
        send(8'hAA); send(8'h00); send(8'h02); send(8'h12); send(8'h34); send(8'hAB);
        #2 rst_n = 1'b0;
        #1 check("midrst_outs", {rom_we, cpu_hold, load_done, load_err, rom_addr, rom_data}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        run_frame('{8'hAA, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE}, 1, "reload");

        // Randomized frames: garbage prefix, random counts up to the depth, random gaps and checksum faults.
        for (int t = 0; t < 20; t++) begin
            int cnt;
            logic [7:0] s;
            f.delete();
            repeat ($urandom_range(0, 2)) begin
                logic [7:0] g;
                g = 8'($urandom_range(0, 255));
                f.push_back(g == 8'hAA ? 8'h55 : g);
            end
            cnt = (t == 0) ? DEPTH : $urandom_range(0, DEPTH);
            f.push_back(8'hAA);
            f.push_back(8'(cnt >> 8));
            f.push_back(8'(cnt));
            s = 8'h00;
            for (int i = 0; i < 2 * cnt; i++) begin
                logic [7:0] d;
                d = 8'($urandom_range(0, 255));
                f.push_back(d);
                s = s + d;
            end
            if ($urandom_range(0, 3) == 0) s = s ^ 8'($urandom_range(1, 255));
            f.push_back(s);
            run_frame(f, $urandom_range(0, 3), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
